// File: rtl/output_score_packer.sv
`default_nettype none
// ============================================================================
//  Module      : output_score_packer
//  Description : Collects ten output-layer neuron sums per frame, quantizes
//                each to an unsigned 8-bit class score (arithmetic shift then
//                clamp to 0..255) and presents the packed 80-bit score vector
//                to the argmax stage with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_score_packer #(
    parameter int SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic [79:0] array,
    output logic        array_valid,
    input  logic        array_ready,
    output logic        frame_err,
    output logic [7:0]  frame_cnt
);

    localparam logic [0:0] c_ST_FILL   = 1'b0;
    localparam logic [0:0] c_ST_HOLD   = 1'b1;
    localparam int         c_NUM_SLOTS = 10;
    localparam logic [3:0] c_LAST_IDX  = 4'd9;

    logic [0:0]         r_state;
    logic [3:0]         r_idx;
    logic               r_err;
    logic [7:0]         r_cnt;

    logic               w_accept;
    logic               w_out_xfer;
    logic signed [15:0] w_shifted;
    logic [7:0]         w_q;

    // Handshake qualifiers; in_ready drops immediately while reset is held.
    assign in_ready    = rst_n & (r_state == c_ST_FILL);
    assign array_valid = (r_state == c_ST_HOLD);
    assign w_accept    = in_valid & in_ready;
    assign w_out_xfer  = (r_state == c_ST_HOLD) & array_ready;

    assign frame_err   = r_err;
    assign frame_cnt   = r_cnt;

    // Sign-preserving scale-down followed by saturation to the 8-bit range.
    assign w_shifted = $signed(in_data) >>> SHIFT;

    always_comb begin
        w_q = w_shifted[7:0];
        if (w_shifted[15]) begin
            w_q = 8'd0;
        end else if (w_shifted > 16'sd255) begin
            w_q = 8'd255;
        end
    end

    // Frame sequencing: slot index, FILL/HOLD state, sticky error, frame count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_FILL;
            r_idx   <= 4'd0;
            r_err   <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                c_ST_FILL: begin
                    if (w_accept) begin
                        if (r_idx == c_LAST_IDX) begin
                            // Tenth score completes the frame even if in_last
                            // was missing; the error is only flagged.
                            r_state <= c_ST_HOLD;
                            r_idx   <= 4'd0;
                            if (!in_last) begin
                                r_err <= 1'b1;
                            end
                        end else if (in_last) begin
                            // Short frame: drop it and restart at slot 0.
                            r_idx <= 4'd0;
                            r_err <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                c_ST_HOLD: begin
                    if (w_out_xfer) begin
                        r_state <= c_ST_FILL;
                        r_idx   <= 4'd0;
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= c_ST_FILL;
                    r_idx   <= 4'd0;
                end
            endcase
        end
    end

    // One byte register per class; only the slot addressed by idx is written.
    generate
        for (genvar g = 0; g < c_NUM_SLOTS; g++) begin : g_slot
            localparam logic [3:0] c_SLOT = 4'(g);
            logic [7:0] r_slot;

            // Capture the quantized score when this slot is the write target.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_slot <= 8'd0;
                end else if (w_accept && (r_idx == c_SLOT)) begin
                    r_slot <= w_q;
                end
            end

            assign array[8*g +: 8] = r_slot;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_output_score_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_output_score_packer
//  Description : Self-checking bench for output_score_packer. A behavioural
//                frame model produces expected score vectors into a queue; a
//                negedge monitor compares DUT outputs against the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_output_score_packer;

    localparam int SHIFT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'd0;
    logic        in_last = 1'b0;
    logic [79:0] array;
    logic        array_valid;
    logic        array_ready = 1'b0;
    logic        frame_err;
    logic [7:0]  frame_cnt;

    always #5 clk = ~clk;

    output_score_packer #(.SHIFT(SHIFT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .array       (array),
        .array_valid (array_valid),
        .array_ready (array_ready),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a frame is a list of ten scores, each the floor of
    // the sum divided by 2**SHIFT, saturated to 0..255.
    // ------------------------------------------------------------------
    bit          m_live = 0;
    bit          m_just_reset = 0;
    bit          m_hold = 0;
    bit          m_err = 0;
    int          m_idx = 0;
    int          m_cnt = 0;
    logic [7:0]  m_slots [10];
    logic [79:0] exp_q [$];

    function automatic logic [7:0] ref_quant(input logic [15:0] d);
        int v, den, q;
        v   = int'($signed(d));
        den = 1 << SHIFT;
        q   = v / den;
        if ((v % den) != 0 && v < 0) q = q - 1;
        if (q < 0)   return 8'd0;
        if (q > 255) return 8'd255;
        return q[7:0];
    endfunction

    function automatic logic [79:0] pack_slots();
        logic [79:0] p;
        for (int k = 0; k < 10; k++) p[8*k +: 8] = m_slots[k];
        return p;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_live       = 1;
            m_just_reset = 1;
            m_hold       = 0;
            m_idx        = 0;
            m_err        = 0;
            m_cnt        = 0;
            for (int k = 0; k < 10; k++) m_slots[k] = 8'd0;
            exp_q.delete();
        end else begin
            m_just_reset = 0;
            if (!m_hold) begin
                if (in_valid) begin
                    m_slots[m_idx] = ref_quant(in_data);
                    if (m_idx == 9) begin
                        if (!in_last) m_err = 1;
                        exp_q.push_back(pack_slots());
                        m_hold = 1;
                        m_idx  = 0;
                    end else if (in_last) begin
                        m_err = 1;
                        m_idx = 0;
                    end else begin
                        m_idx = m_idx + 1;
                    end
                end
            end else if (array_ready) begin
                m_hold = 0;
                m_cnt  = (m_cnt + 1) % 256;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares DUT outputs against the model on every falling edge
    // and pops one expected frame each time array_valid rises.
    // ------------------------------------------------------------------
    bit          mon_prev = 0;
    logic [79:0] cur_exp = '0;

    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready", {79'd0, in_ready}, {79'd0, (!m_hold && rst_n)});
            check("array_valid", {79'd0, array_valid}, {79'd0, m_hold});
            check("frame_err", {79'd0, frame_err}, {79'd0, m_err});
            check("frame_cnt", {72'd0, frame_cnt}, 80'(m_cnt));
            if (m_just_reset) check("array_reset", array, 80'd0);
            if (array_valid && !mon_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_pop: actual=unexpected frame %h required=none", array);
                end else begin
                    cur_exp = exp_q.pop_front();
                end
            end
            if (array_valid) check("array", array, cur_exp);
            mon_prev = array_valid;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc(input bit v, input logic [15:0] d, input bit l, input bit r);
        in_valid    = v;
        in_data     = d;
        in_last     = l;
        array_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(0, 16'd0, 0, 0);
        cyc(0, 16'd0, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (m_hold && n < 50) begin
            cyc(0, 16'd0, 0, 1);
            n++;
        end
        if (m_hold) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: actual=still holding required=frame consumed");
        end
    endtask

    function automatic logic [15:0] rand_data();
        case ($urandom % 4)
            0: return 16'($urandom);
            1: return 16'($urandom_range(0, 4095));
            2: return 16'(-$urandom_range(1, 4096));
            default: return 16'(255 * 16 - 32 + $urandom_range(0, 64));
        endcase
    endfunction

    initial begin
        do_reset();

        // Basic frame: byte k = k, valid one cycle after the 10th input.
        for (int k = 0; k < 10; k++) cyc(1, 16'(16 * k), k == 9, 1);
        check("basic_array", array, 80'h09080706050403020100);
        cyc(0, 16'd0, 0, 1);
        check("basic_cnt", {72'd0, frame_cnt}, 80'd1);

        // Clamping corners in slots 0..2.
        cyc(1, 16'h7FFF, 0, 1);
        cyc(1, 16'hFFFB, 0, 1);
        cyc(1, 16'h0123, 0, 1);
        for (int k = 3; k < 10; k++) cyc(1, 16'd0, k == 9, 1);
        check("clamp_array", array, 80'h000000000000001200FF);
        drain();

        // Backpressure: hold for five cycles with input offered.
        for (int k = 0; k < 10; k++) cyc(1, rand_data(), k == 9, 0);
        for (int k = 0; k < 5; k++) cyc(1, rand_data(), 0, 0);
        check("bp_in_ready", {79'd0, in_ready}, 80'd0);
        cyc(1, rand_data(), 0, 1);
        for (int k = 0; k < 10; k++) cyc(1, rand_data(), k == 9, 1);
        drain();

        // Early last at the 4th input, then a correct frame.
        for (int k = 0; k < 4; k++) cyc(1, rand_data(), k == 3, 1);
        check("early_err", {79'd0, frame_err}, 80'd1);
        for (int k = 0; k < 10; k++) cyc(1, rand_data(), k == 9, 1);
        drain();

        // Missing last on the 10th input.
        for (int k = 0; k < 10; k++) cyc(1, rand_data(), 0, 1);
        check("missing_valid", {79'd0, array_valid}, 80'd1);
        drain();

        // Reset after six inputs discards the partial frame.
        for (int k = 0; k < 6; k++) cyc(1, rand_data(), 0, 1);
        rst_n = 1'b0;
        cyc(0, 16'd0, 0, 1);
        check("rst_in_ready", {79'd0, in_ready}, 80'd0);
        check("rst_array", array, 80'd0);
        check("rst_err", {79'd0, frame_err}, 80'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) cyc(1, rand_data(), k == 9, 1);
        drain();
        check("rst_cnt", {72'd0, frame_cnt}, 80'd1);

        // Randomized traffic with occasional framing faults.
        for (int c = 0; c < 800; c++) begin
            bit l;
            l = (m_idx == 9);
            if ($urandom % 16 == 0) l = ~l;
            cyc(($urandom % 4) != 0, rand_data(), l, ($urandom % 3) != 0);
        end
        drain();

        // Counter wrap after 256 delivered frames.
        do_reset();
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k < 10; k++) cyc(1, rand_data(), k == 9, 1);
            cyc(0, 16'd0, 0, 1);
        end
        check("wrap_cnt", {72'd0, frame_cnt}, 80'd0);
        check("wrap_err", {79'd0, frame_err}, 80'd0);

        cyc(0, 16'd0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
